// File: rtl/rnn_sched_pkg.sv
// Shared types and per-layer configuration tables for the RNN layer scheduler.
// Layer k is handled by FSM state S_L<k>; the tables below are indexed by layer.
package rnn_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L0,
    S_L1,
    S_L2,
    S_L3,
    S_L4,
    S_L5,
    S_OUT
  } state_t;

  localparam int N_LAYERS = 6;

  localparam logic [2:0] L_DENSE1    = 3'd0;
  localparam logic [2:0] L_VAD_GRU   = 3'd1;
  localparam logic [2:0] L_VAD_DENSE = 3'd2;
  localparam logic [2:0] L_NOISE_GRU = 3'd3;
  localparam logic [2:0] L_DEN_GRU   = 3'd4;
  localparam logic [2:0] L_DEN_OUT   = 3'd5;

  localparam logic [2:0] SEL_FEATURE       = 3'd0;
  localparam logic [2:0] SEL_DENSE_OUT     = 3'd1;
  localparam logic [2:0] SEL_VAD_STATE     = 3'd2;
  localparam logic [2:0] SEL_NOISE_INPUT   = 3'd3;
  localparam logic [2:0] SEL_DENOISE_INPUT = 3'd4;
  localparam logic [2:0] SEL_DENOISE_STATE = 3'd5;

  localparam logic [2:0] LAYER_IN_SEL [N_LAYERS] = '{
    SEL_FEATURE, SEL_DENSE_OUT, SEL_VAD_STATE,
    SEL_NOISE_INPUT, SEL_DENOISE_INPUT, SEL_DENOISE_STATE
  };

  localparam logic [7:0] LAYER_IN_LEN [N_LAYERS] = '{
    8'd42, 8'd24, 8'd24, 8'd90, 8'd114, 8'd96
  };

  localparam logic [7:0] LAYER_OUT_LEN [N_LAYERS] = '{
    8'd24, 8'd24, 8'd1, 8'd48, 8'd96, 8'd22
  };

  function automatic logic is_layer(input state_t s);
    return (s != S_IDLE) && (s != S_OUT);
  endfunction

  function automatic logic [2:0] layer_of(input state_t s);
    case (s)
      S_L0:    return L_DENSE1;
      S_L1:    return L_VAD_GRU;
      S_L2:    return L_VAD_DENSE;
      S_L3:    return L_NOISE_GRU;
      S_L4:    return L_DEN_GRU;
      S_L5:    return L_DEN_OUT;
      default: return L_DENSE1;
    endcase
  endfunction

  function automatic state_t layer_state(input logic [2:0] k);
    case (k)
      L_DENSE1:    return S_L0;
      L_VAD_GRU:   return S_L1;
      L_VAD_DENSE: return S_L2;
      L_NOISE_GRU: return S_L3;
      L_DEN_GRU:   return S_L4;
      L_DEN_OUT:   return S_L5;
      default:     return S_L0;
    endcase
  endfunction

endpackage

// File: rtl/rnn_sched_watchdog.sv
// Per-layer watchdog: counts cycles spent in a layer state, restarted at each layer entry.
// The count saturates at TIMEOUT_CYC-1, which is where expire is raised.
module rnn_sched_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload) begin
      cnt <= '0;
    end else if (run && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = run && (cnt == LIMIT);

endmodule

// File: rtl/rnn_layer_sched.sv
// Frame scheduler: runs the six RNN layer engines in order for each accepted frame,
// drives the MAC input select/lengths, GRU state clearing, watchdog and result handshake.
module rnn_layer_sched
  import rnn_sched_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int FCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_valid,
  output logic              frame_ready,
  output logic [5:0]        layer_start,
  input  logic [5:0]        layer_done,
  output logic [2:0]        in_sel,
  output logic [7:0]        in_len,
  output logic [7:0]        out_len,
  input  logic              state_clr_req,
  output logic              state_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_timeout,
  output logic [FCNT_W-1:0] frame_cnt
);

  state_t     state, state_nxt;
  logic [5:0] start_q;
  logic       clear_pending;
  logic [2:0] cur_layer;
  logic [5:0] cur_mask;
  logic       in_layer;
  logic       done_hit;
  logic       wd_reload, wd_expire;
  logic       clr_now, timeout_now, handshake;

  assign in_layer  = is_layer(state);
  assign cur_layer = layer_of(state);
  assign cur_mask  = 6'b000001 << cur_layer;
  // start_q is nonzero only in the entry cycle, so a done seen then is ignored
  assign done_hit  = (start_q == 6'b0) && ((layer_done & cur_mask) != 6'b0);

  always_comb begin
    state_nxt   = state;
    wd_reload   = 1'b0;
    clr_now     = 1'b0;
    timeout_now = 1'b0;
    handshake   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_valid) begin
          clr_now   = clear_pending | state_clr_req;
          state_nxt = S_L0;
          wd_reload = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          handshake = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        if (done_hit) begin
          if (state == S_L5) begin
            state_nxt = S_OUT;
          end else begin
            state_nxt = layer_state(cur_layer + 3'd1);
            wd_reload = 1'b1;
          end
        end else if (wd_expire) begin
          timeout_now = 1'b1;
          state_nxt   = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      start_q       <= '0;
      clear_pending <= 1'b1;
      err_timeout   <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      state   <= state_nxt;
      start_q <= wd_reload ? (6'b000001 << layer_of(state_nxt)) : 6'b0;
      if (timeout_now) begin
        err_timeout <= 1'b1;
      end
      if (handshake) begin
        frame_cnt <= frame_cnt + FCNT_W'(1);
      end
      // a request coinciding with acceptance is served by that frame's clear
      if (timeout_now || (state_clr_req && !clr_now)) begin
        clear_pending <= 1'b1;
      end else if (clr_now) begin
        clear_pending <= 1'b0;
      end
    end
  end

  rnn_sched_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .reload (wd_reload),
    .run    (in_layer),
    .expire (wd_expire)
  );

  assign frame_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign out_valid   = (state == S_OUT);
  assign layer_start = start_q;
  assign state_clr   = clr_now;
  assign in_sel      = in_layer ? LAYER_IN_SEL[cur_layer]  : 3'd0;
  assign in_len      = in_layer ? LAYER_IN_LEN[cur_layer]  : 8'd0;
  assign out_len     = in_layer ? LAYER_OUT_LEN[cur_layer] : 8'd0;

endmodule

// File: doc/rnn_layer_sched.md
# rnn_layer_sched

Frame-level scheduler for the RNNoise-style inference datapath. It accepts one 42-element feature frame per handshake and sequences the six layer engines one at a time, each started by a single-cycle pulse and finished by a done pulse: dense1, VAD GRU, VAD dense, noise GRU, denoise GRU, denoise output dense. For each layer it drives the input-vector select and the input/output lengths to the shared MAC datapath. It also owns GRU state clearing, the per-layer watchdog and the result handshake toward the gain applicator.

## Interface
Parameters:
- TIMEOUT_CYC, 4096: maximum cycles from a layer start to its done before the frame is aborted.
- FCNT_W, 16: width of the frame counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- frame_valid  in  1  a feature frame is available.
- frame_ready  out  1  scheduler accepts a frame.
- layer_start  out  6  one-hot, one-cycle start pulse; bit k starts layer k (0 = dense1 … 5 = denoise output).
- layer_done  in  6  one-hot done pulse from each layer engine.
- in_sel  out  3  input-vector mux code: 0 feature, 1 dense_out, 2 vad_state, 3 noise_input, 4 denoise_input, 5 denoise_state.
- in_len  out  8  active layer input length (42, 24, 24, 90, 114, 96).
- out_len  out  8  active layer output length (24, 24, 1, 48, 96, 22).
- state_clr_req  in  1  request to zero all GRU states before the next frame.
- state_clr  out  1  one-cycle pulse that zeroes the GRU state registers.
- out_valid  out  1  gains and vad are valid.
- out_ready  in  1  consumer takes the result.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  sticky watchdog error; cleared only by rst.
- frame_cnt  out  FCNT_W  completed-frame count; wraps.

## Operation
- FSM states: IDLE, L0 … L5, OUT.
- Reset values:
  - FSM enters IDLE.
  - frame_ready = 1; all other outputs are 0, including in_sel, in_len, out_len and frame_cnt.
  - An internal clear_pending flag is set to 1.
- In IDLE:
  - frame_ready = 1.
  - On frame_valid && frame_ready: if clear_pending is set, pulse state_clr in this cycle and clear the flag. Then go to L0.
- Entering Lk:
  - layer_start[k] is asserted for exactly the entry cycle.
  - in_sel, in_len and out_len are held stable for the whole time in Lk.
  - The watchdog reloads to 0.
- In Lk, layer_done[k]=1 on any cycle after the entry cycle moves the FSM to L(k+1), or to OUT from L5.
- Done bits for other layers are ignored, as is layer_done[k] in the entry cycle.
- In OUT:
  - out_valid is held at 1 until out_ready=1.
  - On that handshake: frame_cnt increments (wrapping to 0 after all ones), out_valid falls and the FSM returns to IDLE.
- Watchdog timeout: if the counter reaches TIMEOUT_CYC-1 in Lk without done, set err_timeout, set clear_pending, and go to IDLE. No out_valid is produced and frame_cnt is unchanged.
- state_clr_req:
  - Sets clear_pending on any cycle.
  - If it arrives in the same cycle as a frame acceptance, the clear is applied to that frame.
- busy = (state != IDLE).

## Timing
- Input length is 8-bit unsigned; the maximum is 114.
- Frame acceptance is cycle 0 and L0 is entered at cycle 1.
- If every engine returns done one cycle after its start, layer k spans 2 cycles, so out_valid first rises at cycle 13.
- A frame can be accepted again on the cycle after out_valid && out_ready; there is no bubble beyond the IDLE cycle.
- A result is never dropped. out_valid stays high while out_ready=0.
- rst asserted mid-frame forces IDLE asynchronously, drops any start pulse, and sets clear_pending so the next frame clears GRU state.

## Structure
- Package rnn_sched_pkg holds:
  - the state enum;
  - layer index constants L_DENSE1 … L_DEN_OUT;
  - the in_sel codes;
  - constant arrays LAYER_IN_LEN and LAYER_OUT_LEN indexed by layer.
- Sub-module rnn_sched_watchdog contains the counter with reload and expire, parameterized by TIMEOUT_CYC.

## Test plan
- After rst, send a frame with each engine's done 1 cycle after its start:
  - state_clr pulses at cycle 0;
  - start pulses fall on cycles 1, 3, 5, 7, 9, 11;
  - in_sel/in_len step through 0/42, 1/24, 2/24, 3/90, 4/114, 5/96;
  - out_valid rises at cycle 13;
  - frame_cnt reads 1 after out_ready.
- Send a second frame without state_clr_req: no state_clr pulse is produced.
- Hold out_ready=0 for 20 cycles: out_valid and frame_ready stay constant (1 and 0) throughout, then a single handshake completes.
- With TIMEOUT_CYC=16, withhold done for layer 3:
  - err_timeout sets 16 cycles after the L3 start and the FSM returns to IDLE;
  - frame_cnt is unchanged;
  - state_clr pulses on the next frame.
- Pulse a stray layer_done[4] during L1, and layer_done[1] in the L1 entry cycle: both are ignored and L1 waits for a later done.
- Assert rst at cycle 6 of a frame: the FSM goes to IDLE with all outputs at 0; the next frame produces state_clr.
